// File: rtl/ysyx_23060208_defs.sv
// rtl/ysyx_23060208_defs.sv - shared constants and CLINT bus FSM state encoding
package ysyx_23060208_defs;

    // AXI read response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Device addresses, also used by the memory arbiter for routing
    localparam logic [31:0] RTC_ADDR    = 32'ha000_0048;
    localparam logic [31:0] SERIAL_ADDR = 32'ha000_03f8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } clint_state_t;

endpackage

// File: rtl/ysyx_23060208_clint_timer.sv
// rtl/ysyx_23060208_clint_timer.sv - prescaled free-running 64-bit mtime counter
//
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   mtime    : current timer value; advances once every TICK_DIV clk cycles
module ysyx_23060208_clint_timer #(
    parameter int TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] mtime
);

    localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

    logic [15:0] prescaler;

    // mtime wraps silently at 2^64-1
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= 16'd0;
            mtime     <= 64'd0;
        end else if (prescaler == DIV_LAST) begin
            prescaler <= 16'd0;
            mtime     <= mtime + 64'd1;
        end else begin
            prescaler <= prescaler + 16'd1;
        end
    end

endmodule

// File: rtl/ysyx_23060208_clint.sv
// rtl/ysyx_23060208_clint.sv - AXI4-Lite read-only CLINT serving mtime low/high words
//
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   araddr/arvalid/    : read address channel (one outstanding transaction)
//   arready
//   rdata/rresp/       : read data channel; OKAY for the two mtime words,
//   rvalid/rready        SLVERR with zero data for any other address
//   mtime_o            : live timer value for debug and difftest
import ysyx_23060208_defs::*;

module ysyx_23060208_clint #(
    parameter int                DATA_WIDTH = 32,
    parameter int                ADDR_WIDTH = 32,
    parameter logic [31:0]       BASE_ADDR  = RTC_ADDR,
    parameter int                TICK_DIV   = 1,
    parameter int                RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [63:0]           mtime_o
);

    localparam logic [ADDR_WIDTH-1:0] LO_ADDR  = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] HI_ADDR  = LO_ADDR + ADDR_WIDTH'(4);
    localparam logic [3:0]            LAT_LOAD = 4'(RD_LATENCY - 1);

    clint_state_t state, next_state;
    logic [3:0]   lat_cnt;
    logic [63:0]  mtime;
    logic [63:0]  snapshot;
    logic         ar_fire;
    logic         r_fire;

    ysyx_23060208_clint_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .mtime (mtime)
    );

    assign mtime_o = mtime;
    assign arready = (state == ST_IDLE) && !rst;
    assign rvalid  = (state == ST_RESP) && !rst;
    assign ar_fire = arvalid && arready;
    assign r_fire  = rvalid && rready;

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (ar_fire) next_state = (RD_LATENCY == 1) ? ST_RESP : ST_WAIT;
            // lat_cnt reaches 0 on this edge, so RESP lands RD_LATENCY cycles after AR
            ST_WAIT: if (lat_cnt == 4'd1) next_state = ST_RESP;
            ST_RESP: if (rready) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            lat_cnt  <= 4'd0;
            rdata    <= '0;
            rresp    <= RESP_OKAY;
            snapshot <= 64'd0;
        end else begin
            state <= next_state;
            if (ar_fire) begin
                lat_cnt <= LAT_LOAD;
                // Low read freezes the whole 64-bit value so the high read is coherent
                if (araddr == LO_ADDR) begin
                    snapshot <= mtime;
                    rdata    <= DATA_WIDTH'(mtime[31:0]);
                    rresp    <= RESP_OKAY;
                end else if (araddr == HI_ADDR) begin
                    rdata    <= DATA_WIDTH'(snapshot[63:32]);
                    rresp    <= RESP_OKAY;
                end else begin
                    rdata    <= '0;
                    rresp    <= RESP_SLVERR;
                end
            end else if (state == ST_WAIT) begin
                lat_cnt <= lat_cnt - 4'd1;
            end
            if (r_fire) begin
                rdata <= '0;
                rresp <= RESP_OKAY;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060208_clint.sv
// tb/tb_ysyx_23060208_clint.sv - directed self-checking bench for ysyx_23060208_clint
module tb_ysyx_23060208_clint;

    localparam logic [31:0] LO  = 32'ha000_0048;
    localparam logic [31:0] HI  = 32'ha000_004c;
    localparam logic [31:0] BAD = 32'ha000_0050;

    logic        clk;
    int          tests;
    int          fails;

    // instance a: TICK_DIV=1, RD_LATENCY=1
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [63:0] mtime;
    logic [63:0] mt_val;

    // instance b: TICK_DIV=4, RD_LATENCY=3
    logic        rst_b;
    logic [31:0] araddr_b;
    logic        arvalid_b;
    logic        arready_b;
    logic [31:0] rdata_b;
    logic [1:0]  rresp_b;
    logic        rvalid_b;
    logic        rready_b;
    logic [63:0] mtime_b;

    ysyx_23060208_clint dut (
        .clk     (clk),
        .rst     (rst),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .mtime_o (mtime)
    );

    ysyx_23060208_clint #(
        .TICK_DIV   (4),
        .RD_LATENCY (3)
    ) dut_b (
        .clk     (clk),
        .rst     (rst_b),
        .araddr  (araddr_b),
        .arvalid (arvalid_b),
        .arready (arready_b),
        .rdata   (rdata_b),
        .rresp   (rresp_b),
        .rvalid  (rvalid_b),
        .rready  (rready_b),
        .mtime_o (mtime_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time expired, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Preload mtime on instance a; called at a negedge, returns 1 time unit later
    task automatic set_mtime(input logic [63:0] v);
        mt_val = v;
        force dut.u_timer.mtime = mt_val;
        #1;
        release dut.u_timer.mtime;
    endtask

    // Full read on instance a with rready held high; call at/after a negedge
    task automatic read_a(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int lat);
        int n;
        araddr  = addr;
        arvalid = 1'b1;
        rready  = 1'b1;
        #1;
        n = 0;
        while (!arready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        tests++;
        if (!arready) begin
            fails++;
            $display("FAIL ar_accept: got arready=%b expected 1", arready);
        end
        @(negedge clk);
        arvalid = 1'b0;
        lat = 1;
        while (!rvalid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        data = rdata;
        resp = rresp;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        int          l;
        rst = 1'b1; arvalid = 1'b0; rready = 1'b0; araddr = 32'd0;
        repeat (3) @(negedge clk);
        tests++;
        if (arready !== 1'b0 || rvalid !== 1'b0 || rdata !== 32'd0 || rresp !== 2'b00) begin
            fails++;
            $display("FAIL reset_outputs: got arready=%b rvalid=%b rdata=%h rresp=%b expected 0 0 0 0",
                     arready, rvalid, rdata, rresp);
        end
        tests++;
        if (mtime !== 64'd0) begin
            fails++;
            $display("FAIL reset_mtime: got %h expected 0", mtime);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            tests++;
            if (arready !== 1'b1) begin
                fails++;
                $display("FAIL idle_arready: cycle %0d got %b expected 1", i, arready);
            end
            @(negedge clk);
        end
        tests++;
        if (mtime !== 64'd10) begin
            fails++;
            $display("FAIL mtime_after_10: got %0d expected 10", mtime);
        end
        read_a(HI, d, r, l);
        tests++;
        if (d !== 32'd0 || r !== 2'b00 || l != 1) begin
            fails++;
            $display("FAIL high_without_low: got data=%h resp=%b lat=%0d expected 0 00 1", d, r, l);
        end
    endtask

    task automatic test_coherent_pair();
        logic [31:0] d;
        logic [1:0]  r;
        int          l;
        set_mtime(64'h0000_0000_ffff_fffe);
        read_a(LO, d, r, l);
        tests++;
        if (d !== 32'hffff_fffe || r !== 2'b00 || l != 1) begin
            fails++;
            $display("FAIL pair_low: got data=%h resp=%b lat=%0d expected fffffffe 00 1", d, r, l);
        end
        tests++;
        if (mtime[63:32] !== 32'd1) begin
            fails++;
            $display("FAIL pair_crossed: got mtime=%h expected high word 1", mtime);
        end
        read_a(HI, d, r, l);
        tests++;
        if (d !== 32'h0 || r !== 2'b00) begin
            fails++;
            $display("FAIL pair_high: got data=%h resp=%b expected 00000000 00", d, r);
        end
    endtask

    task automatic test_bad_addr();
        logic [31:0] d;
        logic [1:0]  r;
        int          l;
        set_mtime(64'h0000_0001_0000_0010);
        read_a(LO, d, r, l);
        tests++;
        if (d !== 32'h10 || r !== 2'b00) begin
            fails++;
            $display("FAIL bad_pre_low: got data=%h resp=%b expected 00000010 00", d, r);
        end
        set_mtime(64'h0000_0007_0000_0000);
        read_a(BAD, d, r, l);
        tests++;
        if (d !== 32'h0 || r !== 2'b10) begin
            fails++;
            $display("FAIL bad_resp: got data=%h resp=%b expected 00000000 10", d, r);
        end
        read_a(HI, d, r, l);
        tests++;
        if (d !== 32'h1 || r !== 2'b00) begin
            fails++;
            $display("FAIL bad_snapshot_kept: got data=%h resp=%b expected 00000001 00", d, r);
        end
    endtask

    task automatic test_backpressure();
        set_mtime(64'h0000_0003_1234_5678);
        araddr = LO; arvalid = 1'b1; rready = 1'b0;
        #1;
        tests++;
        if (arready !== 1'b1) begin
            fails++;
            $display("FAIL bp_accept: got arready=%b expected 1", arready);
        end
        @(negedge clk);
        araddr = HI;
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (rvalid !== 1'b1 || rdata !== 32'h1234_5678 || rresp !== 2'b00 || arready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold: cycle %0d got rvalid=%b rdata=%h rresp=%b arready=%b expected 1 12345678 00 0",
                         i, rvalid, rdata, rresp, arready);
            end
            if (i < 5) @(negedge clk);
        end
        rready = 1'b1;
        #1;
        tests++;
        if (arready !== 1'b0) begin
            fails++;
            $display("FAIL bp_no_early_ar: got arready=%b expected 0", arready);
        end
        @(negedge clk);
        tests++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            fails++;
            $display("FAIL bp_after_r: got rvalid=%b arready=%b expected 0 1", rvalid, arready);
        end
        @(negedge clk);
        arvalid = 1'b0;
        tests++;
        if (rvalid !== 1'b1 || rdata !== 32'h3 || rresp !== 2'b00) begin
            fails++;
            $display("FAIL bp_next_high: got rvalid=%b rdata=%h rresp=%b expected 1 00000003 00",
                     rvalid, rdata, rresp);
        end
        @(negedge clk);
        tests++;
        if (rvalid !== 1'b0) begin
            fails++;
            $display("FAIL bp_done: got rvalid=%b expected 0", rvalid);
        end
    endtask

    task automatic test_prescaler_latency();
        rst_b = 1'b0;
        repeat (7) @(negedge clk);
        tests++;
        if (mtime_b !== 64'd1) begin
            fails++;
            $display("FAIL div4_7cyc: got %0d expected 1", mtime_b);
        end
        @(negedge clk);
        tests++;
        if (mtime_b !== 64'd2) begin
            fails++;
            $display("FAIL div4_8cyc: got %0d expected 2", mtime_b);
        end
        araddr_b = LO; arvalid_b = 1'b1; rready_b = 1'b1;
        #1;
        tests++;
        if (arready_b !== 1'b1) begin
            fails++;
            $display("FAIL lat_accept: got arready=%b expected 1", arready_b);
        end
        @(negedge clk);
        arvalid_b = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            tests++;
            if (rvalid_b !== 1'b0 || arready_b !== 1'b0) begin
                fails++;
                $display("FAIL lat_wait: t+%0d got rvalid=%b arready=%b expected 0 0", k, rvalid_b, arready_b);
            end
            @(negedge clk);
        end
        tests++;
        if (rvalid_b !== 1'b1 || arready_b !== 1'b0 || rdata_b !== 32'd2 || rresp_b !== 2'b00) begin
            fails++;
            $display("FAIL lat_resp: t+3 got rvalid=%b arready=%b rdata=%h rresp=%b expected 1 0 00000002 00",
                     rvalid_b, arready_b, rdata_b, rresp_b);
        end
        @(negedge clk);
        tests++;
        if (rvalid_b !== 1'b0 || arready_b !== 1'b1) begin
            fails++;
            $display("FAIL lat_one_cycle: t+4 got rvalid=%b arready=%b expected 0 1", rvalid_b, arready_b);
        end
    endtask

    task automatic test_mid_reset();
        araddr_b = LO; arvalid_b = 1'b1; rready_b = 1'b1;
        @(negedge clk);
        arvalid_b = 1'b0;
        tests++;
        if (arready_b !== 1'b0 || rvalid_b !== 1'b0) begin
            fails++;
            $display("FAIL mid_in_wait: got arready=%b rvalid=%b expected 0 0", arready_b, rvalid_b);
        end
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        tests++;
        if (mtime_b !== 64'd0 || rvalid_b !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_state: got mtime=%0d rvalid=%b expected 0 0", mtime_b, rvalid_b);
        end
        #1;
        tests++;
        if (arready_b !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset_idle: got arready=%b expected 1", arready_b);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tests++;
            if (rvalid_b !== 1'b0) begin
                fails++;
                $display("FAIL mid_no_resp: cycle %0d got rvalid=%b expected 0", i, rvalid_b);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1; araddr = 32'd0; arvalid = 1'b0; rready = 1'b0;
        rst_b = 1'b1; araddr_b = 32'd0; arvalid_b = 1'b0; rready_b = 1'b0;
        mt_val = 64'd0;
        test_reset();
        test_coherent_pair();
        test_bad_addr();
        test_backpressure();
        test_prescaler_latency();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
